channel_arbiter: RTL
====================

# channel_arbiter

Round-robin burst arbiter that shares one `channel_buffer` input port among `NUM_REQ` producer streams, for example several convolution lanes writing into one inter-layer buffer. A grant holds the shared port for exactly `BURST_LEN` accepted beats, so each producer's tile stays contiguous downstream. Handshakes are valid/ready on both sides. The selected stream is passed through combinationally, with no data storage in this block.

## Interface
- `BIT_WIDTH`, 8, bit width per channel
- `NUM_CHANNEL`, 3, channels per beat (beat width `W = NUM_CHANNEL*BIT_WIDTH`)
- `NUM_REQ`, 4, number of requesters, 2..16
- `BURST_LEN`, 4, beats per grant, ≥1
- `TIMEOUT_CYCLES`, 16, idle-stall limit, ≥1; used only with `CHANNEL_ARB_TIMEOUT_EN`

Ports (name, direction, width, meaning):
- `clk` input 1 — system clock; the only clock
- `rst` input 1 — reset, synchronous, active-high
- `req_valid` input `NUM_REQ` — per-requester valid
- `req_rdy` output `NUM_REQ` — per-requester ready
- `req_data` input `NUM_REQ*W` — requester `i` occupies bits `[i*W +: W]`
- `out_valid` output 1 — valid toward the shared buffer
- `out_rdy` input 1 — ready from the shared buffer
- `out_data` output `W` — selected beat
- `grant_valid` output 1 — a burst is in progress
- `grant_id` output `clog2(NUM_REQ)` — current or last granted requester
- `burst_abort` output 1 — one-cycle pulse on a timeout abort; tied 0 without the macro

## Operation
- State machine with two states, `ARB` and `BURST`.
- Registers:
  - `state`
  - `last_grant`
  - `grant_id`
  - `beat_cnt`, width `clog2(BURST_LEN+1)`
  - `stall_cnt` (macro only)
- **ARB state:**
  - Search `req_valid` starting at `last_grant+1`, wrapping modulo `NUM_REQ`.
  - If the first asserted index is `k`: next cycle `grant_id=k`, `last_grant=k`, `beat_cnt=0`, go to `BURST`.
  - If no valid is asserted, stay in `ARB`.
  - Outputs in `ARB`: `out_valid=0`, `req_rdy=0`, `out_data=0`.
- **BURST state:**
  - `out_valid = req_valid[grant_id]`.
  - `out_data = req_data[grant_id]`.
  - `req_rdy[grant_id] = out_rdy`; all other `req_rdy` bits are 0.
  - A beat is accepted when `out_valid && out_rdy`; each accepted beat increments `beat_cnt`.
  - The beat that brings `beat_cnt` to `BURST_LEN` returns the FSM to `ARB` on the next cycle.
  - A requester dropping valid mid-burst does not release the grant.
- `grant_valid = (state == BURST)`.
- `grant_id` holds its value in `ARB` until the next grant.
- **Fairness:** a requester that stays valid is granted within `NUM_REQ-1` intervening bursts.
- `out_rdy` never reaches `req_rdy` while in `ARB`. There is no combinational path from `req_valid` to `req_rdy` in `ARB`.
- **Reset:** `rst` in any cycle, including mid-burst, forces on the next edge:
  - `state=ARB`, `last_grant=NUM_REQ-1` (requester 0 has first priority)
  - `grant_id=0`, `beat_cnt=0`, `stall_cnt=0`
  - A partial burst is dropped, with no completion.
- **Reset values of outputs:** `out_valid=0`, `out_data=0`, `req_rdy=0`, `grant_valid=0`, `grant_id=0`, `burst_abort=0`.

## Timing
- Grant latency is one cycle: a request sampled in `ARB` at edge N gives `req_rdy` and pass-through from cycle N+1.
- Per-burst overhead is one `ARB` bubble. Maximum throughput is `BURST_LEN/(BURST_LEN+1)` beats per cycle.
- Data path latency is zero; `out_data` is combinational from `req_data`.
- `BURST_LEN=1` gives a grant, one beat, `ARB`, alternating.
- Last beat and a new request in the same cycle: the new request is evaluated in the following `ARB` cycle. Priority uses the updated `last_grant`.

## Configuration
- `CHANNEL_ARB_TIMEOUT_EN` defined:
  - In `BURST`, `stall_cnt` increments on each cycle where `req_valid[grant_id]=0`.
  - `stall_cnt` clears on any cycle where `req_valid[grant_id]=1`.
  - On reaching `TIMEOUT_CYCLES`: go to `ARB`, pulse `burst_abort` for one cycle, clear `beat_cnt` and `stall_cnt`.
  - `last_grant` keeps the aborted id.
  - Stalls from `out_rdy=0` do not count toward the timeout.
- `CHANNEL_ARB_TIMEOUT_EN` undefined:
  - No `stall_cnt`; `burst_abort` is constant 0.
  - A burst holds the port until `BURST_LEN` beats are accepted.

## Test plan
1. **Reset and single requester:**
   - Stimulus: `rst` for 2 cycles, then `req_valid=4'b0010` continuously, `out_rdy=1`.
   - Required: `grant_id=1` one cycle after; beats of requester 1 on `out_data`; `grant_valid` low for exactly 1 cycle every 5.
2. **Round-robin rotation:**
   - Stimulus: all four requesters valid, `out_rdy=1`.
   - Required: `grant_id` sequence 0,1,2,3,0; each grant carries exactly 4 beats; non-granted `req_rdy` always 0.
3. **Backpressure:**
   - Stimulus: `out_rdy` toggles 1,0,1,0 during a burst.
   - Required: `beat_cnt` advances only on accepted beats; burst ends after the 4th accepted beat; no beat lost or duplicated (scoreboard per requester).
4. **Skip empty requesters:**
   - Stimulus: `last_grant=0`, `req_valid=4'b1001`.
   - Required: next grant is 3, then 0.
5. **Mid-burst reset:**
   - Stimulus: assert `rst` after 2 beats of a burst from requester 2.
   - Required: next cycle all outputs at reset values; first grant after release goes to the lowest-index valid requester.
6. **Timeout (macro defined, `TIMEOUT_CYCLES=16`):**
   - Stimulus: granted requester sends 1 beat, then drops valid.
   - Required: `burst_abort` pulses 16 cycles later; the next valid requester is granted the cycle after `ARB`.
   - Without the macro: the grant holds indefinitely.

Source files
------------

// File: rtl/channel_arbiter.sv
// channel_arbiter: round-robin burst arbiter that shares one buffer input port
// among NUM_REQ valid/ready producer streams. A grant holds the port for
// BURST_LEN accepted beats. The selected stream passes through combinationally.
//
// Optional feature: define CHANNEL_ARB_TIMEOUT_EN to abort a burst after
// TIMEOUT_CYCLES consecutive cycles with the granted requester's valid low.
//
// state | meaning
// ARB   | no grant; search req_valid from last_grant+1, one bubble per burst
// BURST | port owned by grant_id until BURST_LEN beats are accepted
module channel_arbiter #(
  parameter int BIT_WIDTH      = 8,
  parameter int NUM_CHANNEL    = 3,
  parameter int NUM_REQ        = 4,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_rdy,
  input  logic [NUM_REQ*NUM_CHANNEL*BIT_WIDTH-1:0]  req_data,
  output logic                                      out_valid,
  input  logic                                      out_rdy,
  output logic [NUM_CHANNEL*BIT_WIDTH-1:0]          out_data,
  output logic                                      grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]                grant_id,
  output logic                                      burst_abort
);

  localparam int W     = NUM_CHANNEL * BIT_WIDTH;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant, last_nxt;
  logic [ID_W-1:0]   gid_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_nxt;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  int                idx;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef CHANNEL_ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [ST_W-1:0] stall_cnt, stall_nxt;
  logic            abort_nxt;
  logic            abort_q;
`endif

  // Next-state, counters and pass-through outputs.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    gid_nxt   = grant_id;
    beat_nxt  = beat_cnt;
    out_valid = 1'b0;
    out_data  = '0;
    req_rdy   = '0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    stall_nxt = '0;
    abort_nxt = 1'b0;
`endif
    case (state)
      ARB: begin
        if (found) begin
          state_nxt = BURST;
          gid_nxt   = pick;
          last_nxt  = pick;
          beat_nxt  = '0;
        end
      end
      BURST: begin
        out_valid         = req_valid[grant_id];
        out_data          = req_data[grant_id*W +: W];
        req_rdy[grant_id] = out_rdy;
        if (req_valid[grant_id] && out_rdy) begin
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            state_nxt = ARB;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + CNT_W'(1);
          end
        end
`ifdef CHANNEL_ARB_TIMEOUT_EN
        // Only a missing valid counts as a stall; backpressure never does.
        if (!req_valid[grant_id]) begin
          if (stall_cnt == ST_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = ARB;
            beat_nxt  = '0;
            stall_nxt = '0;
            abort_nxt = 1'b1;
          end else begin
            stall_nxt = stall_cnt + ST_W'(1);
          end
        end
`endif
      end
      default: state_nxt = ARB;
    endcase
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      grant_id   <= gid_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

`ifdef CHANNEL_ARB_TIMEOUT_EN
  // Stall counter and registered one-cycle abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      abort_q   <= abort_nxt;
    end
  end

  assign burst_abort = abort_q;
`else
  assign burst_abort = 1'b0;
`endif

  assign grant_valid = (state == BURST);

endmodule
